// File: rtl/rx_decode_ctrl_if.sv
// rx_decode_ctrl_if: protocol-FSM and decode-path signals of the receive sequencer
interface rx_decode_ctrl_if #(parameter int CNT_W = 10);
  logic rx_enable;
  logic expect_data;
  logic sync_det;
  logic bit_valid;
  logic eop_det;
  logic PID_error;
  logic bs_decoder_wait;
  logic crc_done;
  logic crc_ok;
  logic start_decode;
  logic end_decode;
  logic rc_PIDerror;
  logic abort;
  logic pkt_done;
  logic pkt_ok;
  logic [1:0] pkt_type;
  logic [CNT_W-1:0] bit_cnt;
  logic busy;
  modport master (
    input rx_enable, expect_data, sync_det, bit_valid, eop_det, PID_error, bs_decoder_wait, crc_done, crc_ok,
    output start_decode, end_decode, rc_PIDerror, abort, pkt_done, pkt_ok, pkt_type, bit_cnt, busy
  );
  modport slave (
    output rx_enable, expect_data, sync_det, bit_valid, eop_det, PID_error, bs_decoder_wait, crc_done, crc_ok,
    input start_decode, end_decode, rc_PIDerror, abort, pkt_done, pkt_ok, pkt_type, bit_cnt, busy
  );
endinterface

// File: rtl/rx_decode_ctrl.sv
// rx_decode_ctrl: sequences one received packet through unstuff/decode/CRC and issues a single verdict
module rx_decode_ctrl #(
  parameter int TIMEOUT  = 255,
  parameter int MAX_BITS = 536,
  parameter int CNT_W    = 10
) (
  input logic clk,
  input logic rst,
  rx_decode_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, ARM, RECV, CHECK, PIDACK, DONE, FAIL} state_t;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_BITS);
  state_t state, next;
  logic [CNT_W-1:0] tcnt, bit_cnt;
  logic is_data, crc_seen, crc_good, to_hit, over, len_ok, abort_nx;
  assign to_hit = tcnt == TO_LAST;
  assign over = bus.bit_valid && bit_cnt == MAX;
  assign len_ok = is_data ? (bit_cnt >= CNT_W'(24) && bit_cnt[2:0] == 3'd0 && bit_cnt <= MAX) : bit_cnt == CNT_W'(8);
  assign bus.bit_cnt = bit_cnt;
  assign bus.busy = state != IDLE;
  always_comb begin
    next = state;
    abort_nx = 1'b0;
    bus.start_decode = 1'b0;
    bus.end_decode = 1'b0;
    case (state)
      IDLE: next = bus.rx_enable ? ARM : IDLE;
      ARM: begin
        next = bus.sync_det ? RECV : to_hit ? FAIL : ARM;
        abort_nx = !bus.sync_det && to_hit;
      end
      RECV: begin
        bus.start_decode = bus.bit_valid && bit_cnt == '0;
        bus.end_decode = bus.eop_det;
        next = bus.eop_det ? CHECK : over ? FAIL : RECV;
        abort_nx = !bus.eop_det && over;
      end
      CHECK: begin
        next = bus.PID_error ? PIDACK : (bus.bs_decoder_wait && (!is_data || crc_seen)) ? DONE : to_hit ? FAIL : CHECK;
        abort_nx = next == FAIL;
      end
      PIDACK: next = FAIL;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tcnt <= '0;
      bit_cnt <= '0;
      is_data <= 1'b0;
      crc_seen <= 1'b0;
      crc_good <= 1'b0;
      bus.rc_PIDerror <= 1'b0;
      bus.abort <= 1'b0;
      bus.pkt_done <= 1'b0;
      bus.pkt_ok <= 1'b0;
      bus.pkt_type <= 2'b00;
    end else begin
      state <= next;
      tcnt <= next != state ? '0 : tcnt + 1'b1;
      if (state == IDLE && bus.rx_enable) begin
        is_data <= bus.expect_data;
        bit_cnt <= '0;
        crc_seen <= 1'b0;
        crc_good <= 1'b0;
      end
      if (state == RECV && bus.bit_valid && !bus.eop_det && !over)
        bit_cnt <= bit_cnt + 1'b1;
      if ((state == RECV || state == CHECK) && bus.crc_done) begin
        crc_seen <= 1'b1;
        crc_good <= bus.crc_ok;
      end
      bus.rc_PIDerror <= next == PIDACK;
      bus.abort <= abort_nx;
      bus.pkt_done <= next == DONE || next == FAIL;
      if (next == DONE) begin
        bus.pkt_ok <= len_ok && (!is_data || crc_good);
        bus.pkt_type <= {1'b1, is_data};
      end
      if (next == FAIL) begin
        bus.pkt_ok <= 1'b0;
        bus.pkt_type <= abort_nx ? 2'b00 : {1'b1, is_data};
      end
    end
  end
endmodule

// File: tb/tb_rx_decode_ctrl.sv
// tb_rx_decode_ctrl: randomized packet-level check of rx_decode_ctrl against a verdict model
module tb_rx_decode_ctrl;
  localparam int TIMEOUT = 16;
  localparam int MAX_BITS = 48;
  localparam int CNT_W = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int start_cnt = 0, start_bit_cnt = 0, end_cnt = 0, end_eop_cnt = 0;
  int abort_cnt = 0, abort_done_cnt = 0, done_cnt = 0, rc_cnt = 0, rc_long_cnt = 0;
  logic rc_prev = 1'b0;
  logic last_ok = 1'b0;
  logic [1:0] last_type = 2'b00;
  logic [CNT_W-1:0] last_bits = '0;
  always #5 clk = ~clk;
  rx_decode_ctrl_if #(.CNT_W(CNT_W)) bus();
  rx_decode_ctrl #(.TIMEOUT(TIMEOUT), .MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always @(negedge clk) begin
    start_cnt <= start_cnt + int'(bus.start_decode);
    start_bit_cnt <= start_bit_cnt + int'(bus.start_decode && bus.bit_valid);
    end_cnt <= end_cnt + int'(bus.end_decode);
    end_eop_cnt <= end_eop_cnt + int'(bus.end_decode && bus.eop_det);
    abort_cnt <= abort_cnt + int'(bus.abort);
    abort_done_cnt <= abort_done_cnt + int'(bus.abort && bus.pkt_done);
    rc_cnt <= rc_cnt + int'(bus.rc_PIDerror);
    rc_long_cnt <= rc_long_cnt + int'(bus.rc_PIDerror && rc_prev);
    rc_prev <= bus.rc_PIDerror;
    done_cnt <= done_cnt + int'(bus.pkt_done);
    if (bus.pkt_done) begin
      last_ok <= bus.pkt_ok;
      last_type <= bus.pkt_type;
      last_bits <= bus.bit_cnt;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_pkt(input bit is_data, input int nbits, input bit crc_good, input bit pid_err,
                         input bit eop_bit, input bit no_crc, input int crc_dly);
    int s_start = start_cnt, s_start_bit = start_bit_cnt, s_end = end_cnt, s_end_eop = end_eop_cnt;
    int s_abort = abort_cnt, s_abort_done = abort_done_cnt, s_done = done_cnt, s_rc = rc_cnt, s_rc_long = rc_long_cnt;
    bit over = nbits > MAX_BITS;
    int nstrobe = over ? MAX_BITS + 1 : nbits;
    bit pid_eff = pid_err && !over;
    bit len_ok = is_data ? (nbits >= 24 && nbits % 8 == 0 && nbits <= MAX_BITS) : nbits == 8;
    bit to_abort = over || (is_data && no_crc && !pid_err);
    bit exp_ok = !to_abort && !pid_eff && len_ok && (!is_data || crc_good);
    logic [1:0] exp_type = to_abort ? 2'b00 : {1'b1, is_data};
    int exp_start = (nbits > 0 || (eop_bit && !over)) ? 1 : 0;
    int waited = 0;
    bus.expect_data = is_data;
    bus.rx_enable = 1'b1;
    tick();
    bus.rx_enable = 1'b0;
    bus.expect_data = 1'($urandom_range(0, 1));
    repeat ($urandom_range(0, 5)) tick();
    bus.sync_det = 1'b1;
    tick();
    bus.sync_det = 1'b0;
    for (int i = 0; i < nstrobe; i++) begin
      bus.bit_valid = 1'b1;
      tick();
      bus.bit_valid = 1'b0;
      if (i < nstrobe - 1 && $urandom_range(0, 3) == 0) begin
        bus.rx_enable = 1'b1;
        bus.sync_det = 1'($urandom_range(0, 1));
        tick();
        bus.rx_enable = 1'b0;
        bus.sync_det = 1'b0;
      end
    end
    if (!over) begin
      bus.eop_det = 1'b1;
      bus.bit_valid = eop_bit;
      bus.bs_decoder_wait = !pid_err;
      tick();
      bus.eop_det = 1'b0;
      bus.bit_valid = 1'b0;
      if (pid_err) begin
        bus.PID_error = 1'b1;
        tick();
        bus.PID_error = 1'b0;
      end else if (is_data && !no_crc) begin
        repeat (crc_dly) tick();
        bus.crc_done = 1'b1;
        bus.crc_ok = crc_good;
        tick();
        bus.crc_done = 1'b0;
        bus.crc_ok = 1'($urandom_range(0, 1));
      end
    end
    while (done_cnt == s_done && waited < 40) begin
      tick();
      waited++;
    end
    repeat (2) tick();
    check("pkt_done_count", done_cnt - s_done, 1);
    check("pkt_ok", last_ok, exp_ok);
    check("pkt_type", last_type, exp_type);
    check("bit_cnt", last_bits, over ? MAX_BITS : nbits);
    check("abort_count", abort_cnt - s_abort, to_abort);
    check("abort_with_done", abort_done_cnt - s_abort_done, to_abort);
    check("rc_PIDerror_count", rc_cnt - s_rc, pid_eff);
    check("rc_PIDerror_width", rc_long_cnt - s_rc_long, 0);
    check("start_decode_count", start_cnt - s_start, exp_start);
    check("start_with_bit", start_bit_cnt - s_start_bit, exp_start);
    check("end_decode_count", end_cnt - s_end, !over);
    check("end_with_eop", end_eop_cnt - s_end_eop, !over);
    check("busy_after", bus.busy, 0);
    bus.bs_decoder_wait = 1'b0;
    tick();
  endtask
  task automatic arm_timeout();
    int k = 1;
    bus.expect_data = 1'b1;
    bus.rx_enable = 1'b1;
    tick();
    bus.rx_enable = 1'b0;
    while (k < 40) begin
      @(negedge clk);
      if (bus.pkt_done) break;
      tick();
      k++;
    end
    check("arm_timeout_cycles", k, TIMEOUT + 1);
    check("arm_timeout_abort", bus.abort, 1);
    check("arm_timeout_ok", bus.pkt_ok, 0);
    check("arm_timeout_type", bus.pkt_type, 0);
    tick();
    tick();
    check("arm_timeout_idle", bus.busy, 0);
  endtask
  task automatic reset_mid();
    int s_done = done_cnt, s_abort = abort_cnt;
    bus.expect_data = 1'b0;
    bus.rx_enable = 1'b1;
    tick();
    bus.rx_enable = 1'b0;
    bus.sync_det = 1'b1;
    tick();
    bus.sync_det = 1'b0;
    repeat (5) begin
      bus.bit_valid = 1'b1;
      tick();
      bus.bit_valid = 1'b0;
    end
    check("rst_mid_busy_before", bus.busy, 1);
    check("rst_mid_bits_before", bus.bit_cnt, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_bit_cnt", bus.bit_cnt, 0);
    repeat (3) tick();
    check("rst_mid_no_done", done_cnt - s_done, 0);
    check("rst_mid_no_abort", abort_cnt - s_abort, 0);
  endtask
  initial begin
    bus.rx_enable = 1'b0;
    bus.expect_data = 1'b0;
    bus.sync_det = 1'b0;
    bus.bit_valid = 1'b0;
    bus.eop_det = 1'b0;
    bus.PID_error = 1'b0;
    bus.bs_decoder_wait = 1'b0;
    bus.crc_done = 1'b0;
    bus.crc_ok = 1'b0;
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_pkt_done", bus.pkt_done, 0);
    check("rst_abort", bus.abort, 0);
    check("rst_pkt_ok", bus.pkt_ok, 0);
    check("rst_pkt_type", bus.pkt_type, 0);
    check("rst_bit_cnt", bus.bit_cnt, 0);
    check("rst_rc_PIDerror", bus.rc_PIDerror, 0);
    rst = 1'b0;
    tick();
    run_pkt(0, 8, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("held_pkt_type", bus.pkt_type, 2);
    check("held_pkt_ok", bus.pkt_ok, 1);
    run_pkt(1, 40, 1, 0, 0, 0, 2);
    run_pkt(1, 40, 0, 0, 0, 0, 2);
    run_pkt(0, 8, 0, 1, 0, 0, 0);
    run_pkt(1, 40, 1, 1, 0, 0, 0);
    arm_timeout();
    run_pkt(1, MAX_BITS + 1, 1, 0, 0, 0, 0);
    run_pkt(1, 30, 1, 0, 0, 0, 1);
    run_pkt(0, 9, 0, 0, 0, 0, 0);
    run_pkt(1, 40, 1, 0, 1, 0, 1);
    run_pkt(1, 40, 1, 0, 0, 1, 0);
    run_pkt(1, MAX_BITS, 1, 0, 0, 0, 0);
    reset_mid();
    repeat (40) begin
      bit d = 1'($urandom_range(0, 1));
      int n;
      case ($urandom_range(0, 3))
        0: n = d ? 8 * int'($urandom_range(3, 6)) : 8;
        1: n = int'($urandom_range(0, MAX_BITS + 3));
        2: n = 8 * int'($urandom_range(1, 6));
        default: n = d ? 8 * int'($urandom_range(3, 6)) : int'($urandom_range(7, 9));
      endcase
      run_pkt(d, n, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) == 0, int'($urandom_range(0, 6)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
